pkt_dispatch_ctrl: RTL

Parametrised bloom-gated packet dispatch controller for N RISC-V inspection cores. It sits between the input packet FIFO FSM and the core array. It snoops the NetFPGA input stream, extracts a key word per packet, and runs a k=3 bloom check against a software-loaded filter. Matching packets are held until every core reports done, or until an optional watchdog expires; non-matching packets are released immediately.

---
 rtl/dispatch_pkg.sv | 17 +
 rtl/bloom_key_check.sv | 31 +++
 rtl/pkt_dispatch_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the bloom-gated packet dispatch controller:
// FSM encoding, hash count and the bloom index-width helper.
package dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam int NUM_HASH = 3;

   function automatic int idx_w(input int filter_w);
      return $clog2(filter_w);
   endfunction

endpackage

// File: rtl/bloom_key_check.sv
// Combinational k=3 bloom membership test of a packet key against the filter.
// Each probe index is the XOR of two IW-bit key fields.
module bloom_key_check
   import dispatch_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int FILTER_W = 64
) (
   input  logic [DATA_W-1:0]   key,
   input  logic [FILTER_W-1:0] filter,
   output logic                hit
);

   localparam int IW = idx_w(FILTER_W);

   logic [NUM_HASH-1:0] probe;

   for (genvar i = 0; i < NUM_HASH; i++) begin : g_hash
      logic [IW-1:0] idx;
      assign idx      = key[i*IW +: IW] ^ key[(i+NUM_HASH)*IW +: IW];
      assign probe[i] = filter[idx];
   end

   assign hit = &probe;

   if (DATA_W > 2*NUM_HASH*IW) begin : g_key_hi
      logic unused_key_hi;
      assign unused_key_hi = ^key[DATA_W-1:2*NUM_HASH*IW];
   end

endmodule

// File: rtl/pkt_dispatch_ctrl.sv
// Bloom-gated dispatch: parses the snooped stream, queues one hit bit per packet
// and holds matching packets until all cores finish. Optional watchdog: DISPATCH_TIMEOUT_EN.
module pkt_dispatch_ctrl
   import dispatch_pkg::*;
#(
   parameter int NUM_CORES      = 2,
   parameter int DATA_W         = 64,
   parameter int CTRL_W         = 8,
   parameter int FILTER_W       = 64,
   parameter int KEY_WORD       = 1,
   parameter int HIT_DEPTH      = 4,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic                 in_wr,
   input  logic [FILTER_W-1:0]  filter,
   input  logic                 pkt_ready,
   input  logic [NUM_CORES-1:0] core_done,
   output logic [NUM_CORES-1:0] core_en,
   output logic                 pkt_release,
   output logic                 timed_out,
   output logic                 hitq_ovf,
   output logic [CNT_W-1:0]     match_count,
   output logic [CNT_W-1:0]     timeout_count,
   output logic [1:0]           state
);

   // HIT_DEPTH is a power of two, at least 2
   localparam int AW     = $clog2(HIT_DEPTH);
   localparam int BCNT_W = $clog2(KEY_WORD + 2);
   localparam logic [BCNT_W-1:0] KEY_IDX  = BCNT_W'(KEY_WORD);
   localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(KEY_WORD + 1);
   localparam logic [AW:0]       HQ_FULL  = (AW+1)'(HIT_DEPTH);

   // ---------------- beat parser ----------------
   logic              data_ph_q, data_ph_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic              eop;
   logic              hit;

   always_comb begin
      data_ph_d = data_ph_q;
      bcnt_d    = bcnt_q;
      key_d     = key_q;
      eop       = 1'b0;
      if (in_wr) begin
         if (in_ctrl == '0) begin
            data_ph_d = 1'b1;
            if (bcnt_q == KEY_IDX) key_d = in_data;
            if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 1'b1;
         end else if (data_ph_q) begin
            // key returns to 0 so a short next packet checks against key=0
            eop       = 1'b1;
            data_ph_d = 1'b0;
            bcnt_d    = '0;
            key_d     = '0;
         end
      end
   end

   bloom_key_check #(
      .DATA_W   (DATA_W),
      .FILTER_W (FILTER_W)
   ) u_bloom (
      .key    (key_q),
      .filter (filter),
      .hit    (hit)
   );

   // ---------------- hit queue ----------------
   logic [HIT_DEPTH-1:0] hq_mem_q, hq_mem_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          hq_cnt_q, hq_cnt_d;
   logic                 hitq_ovf_q, hitq_ovf_d;
   logic                 pop, pop_hit, hq_empty, hq_full, real_pop, push_ok;

   assign hq_empty = (hq_cnt_q == '0);
   assign hq_full  = (hq_cnt_q == HQ_FULL);
   // an empty pop decides as hit so the packet still gets inspected
   assign pop_hit  = hq_empty | hq_mem_q[rd_ptr_q];
   assign real_pop = pop & ~hq_empty;
   assign push_ok  = eop & (~hq_full | real_pop);

   always_comb begin
      hq_mem_d   = hq_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      hq_cnt_d   = hq_cnt_q;
      hitq_ovf_d = hitq_ovf_q | (eop & ~push_ok);
      if (push_ok) begin
         hq_mem_d[wr_ptr_q] = hit;
         wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      if (real_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !real_pop) hq_cnt_d = hq_cnt_q + 1'b1;
      else if (!push_ok && real_pop) hq_cnt_d = hq_cnt_q - 1'b1;
   end

   // ---------------- dispatch FSM ----------------
   state_e               state_q, state_d;
   logic [NUM_CORES-1:0] done_lat_q, done_lat_d, core_en_q, core_en_d, done_all;
   logic                 pkt_release_q, pkt_release_d;
   logic                 timed_out_q, timed_out_d;
   logic [CNT_W-1:0]     match_count_q, match_count_d;
   logic                 wd_expire;

   assign done_all = done_lat_q | core_done;

   always_comb begin
      state_d       = state_q;
      done_lat_d    = done_lat_q;
      core_en_d     = core_en_q;
      pkt_release_d = 1'b0;
      timed_out_d   = 1'b0;
      match_count_d = match_count_q;
      pop           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pkt_ready) begin
               pop = 1'b1;
               if (pop_hit) begin
                  state_d    = RUN;
                  done_lat_d = '0;
                  core_en_d  = '1;
                  if (match_count_q != '1) match_count_d = match_count_q + 1'b1;
               end else begin
                  state_d       = RELEASE;
                  pkt_release_d = 1'b1;
               end
            end
         end
         RUN: begin
            done_lat_d = done_all;
            core_en_d  = ~done_all;
            // completion wins over a watchdog expiry in the same cycle
            if (&done_all) begin
               state_d       = RELEASE;
               pkt_release_d = 1'b1;
               core_en_d     = '0;
            end else if (wd_expire) begin
               state_d       = RELEASE;
               pkt_release_d = 1'b1;
               timed_out_d   = 1'b1;
               core_en_d     = '0;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef DISPATCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0]  wd_q, wd_d;
   logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

   // wd_q is 0 in the first RUN cycle, so expiry lands on cycle TIMEOUT_CYCLES
   assign wd_expire = (state_q == RUN) && (wd_q == WD_LAST);

   always_comb begin
      wd_d            = '0;
      timeout_count_d = timeout_count_q;
      if (state_q == RUN) wd_d = wd_q + 1'b1;
      if (timed_out_d && (timeout_count_q != '1)) timeout_count_d = timeout_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q            <= '0;
         timeout_count_q <= '0;
      end else begin
         wd_q            <= wd_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign timeout_count = timeout_count_q;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign wd_expire      = 1'b0;
   assign timeout_count  = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         data_ph_q     <= 1'b0;
         bcnt_q        <= '0;
         key_q         <= '0;
         hq_mem_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         hq_cnt_q      <= '0;
         hitq_ovf_q    <= 1'b0;
         state_q       <= IDLE;
         done_lat_q    <= '0;
         core_en_q     <= '0;
         pkt_release_q <= 1'b0;
         timed_out_q   <= 1'b0;
         match_count_q <= '0;
      end else begin
         data_ph_q     <= data_ph_d;
         bcnt_q        <= bcnt_d;
         key_q         <= key_d;
         hq_mem_q      <= hq_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         hq_cnt_q      <= hq_cnt_d;
         hitq_ovf_q    <= hitq_ovf_d;
         state_q       <= state_d;
         done_lat_q    <= done_lat_d;
         core_en_q     <= core_en_d;
         pkt_release_q <= pkt_release_d;
         timed_out_q   <= timed_out_d;
         match_count_q <= match_count_d;
      end
   end

   assign core_en     = core_en_q;
   assign pkt_release = pkt_release_q;
   assign timed_out   = timed_out_q;
   assign hitq_ovf    = hitq_ovf_q;
   assign match_count = match_count_q;
   assign state       = state_q;

endmodule
